traffic_ctrl_n: RTL

TRAFFIC_CTRL_N -- requirements
Module: traffic_ctrl_n

---
 rtl/traffic_pkg.sv | 24 ++
 rtl/traffic_ctrl_n_if.sv | 26 ++
 rtl/tl_phase_timer.sv | 24 ++
 rtl/traffic_ctrl_n.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared definitions for the N-approach traffic light controller:
// lamp codes, controller states and default phase durations.
package traffic_pkg;

    typedef enum logic [1:0] {
        LAMP_GREEN  = 2'b00,
        LAMP_YELLOW = 2'b01,
        LAMP_RED    = 2'b10,
        LAMP_OFF    = 2'b11
    } lamp_t;

    typedef enum logic [1:0] {
        S_GREEN  = 2'd0,
        S_YELLOW = 2'd1,
        S_ALLRED = 2'd2,
        S_FLASH  = 2'd3
    } state_e;

    localparam int DEF_GREEN_CYC  = 8;
    localparam int DEF_YELLOW_CYC = 3;
    localparam int DEF_ALLRED_CYC = 2;
    localparam int DEF_FLASH_CYC  = 4;

endpackage

// File: rtl/traffic_ctrl_n_if.sv
// Control and lamp bundle between an intersection supervisor (master)
// and the traffic_ctrl_n controller (slave).
interface traffic_ctrl_n_if #(
    parameter int N_DIR = 2
);
    localparam int DW = $clog2(N_DIR);

    logic                 en;
    logic [N_DIR-1:0]     ped_req;
    logic                 flash_mode;
    logic [2*N_DIR-1:0]   light;
    logic [N_DIR-1:0]     walk;
    logic [DW-1:0]        active_dir;
    logic                 flashing;

    modport master (
        output en, ped_req, flash_mode,
        input  light, walk, active_dir, flashing
    );

    modport slave (
        input  en, ped_req, flash_mode,
        output light, walk, active_dir, flashing
    );

endinterface

// File: rtl/tl_phase_timer.sv
// Phase down-counter: load has priority, otherwise counts down on enabled
// ticks and parks at zero; o_zero flags the last tick of a phase.
module tl_phase_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_en,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (i_load)
            r_cnt <= i_load_val;
        else if (i_en && (r_cnt != '0))
            r_cnt <= r_cnt - 1'b1;
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/traffic_ctrl_n.sv
// Round-robin traffic light controller for N_DIR approaches with sticky
// pedestrian requests and a flashing fault/night mode; all outputs registered.
module traffic_ctrl_n
    import traffic_pkg::*;
#(
    parameter int N_DIR      = 2,
    parameter int CNT_W      = 8,
    parameter int GREEN_CYC  = DEF_GREEN_CYC,
    parameter int YELLOW_CYC = DEF_YELLOW_CYC,
    parameter int ALLRED_CYC = DEF_ALLRED_CYC,
    parameter int FLASH_CYC  = DEF_FLASH_CYC
) (
    input  logic             clk,
    input  logic             reset,
    traffic_ctrl_n_if.slave  bus
);

    localparam int DW = $clog2(N_DIR);

    localparam logic [1:0] ST_GREEN  = S_GREEN;
    localparam logic [1:0] ST_YELLOW = S_YELLOW;
    localparam logic [1:0] ST_ALLRED = S_ALLRED;
    localparam logic [1:0] ST_FLASH  = S_FLASH;

    logic [1:0]         r_state;
    logic [DW-1:0]      r_dir;
    logic               r_off;
    logic [N_DIR-1:0]   r_pend;
    logic [N_DIR-1:0]   r_walk;
    logic [2*N_DIR-1:0] r_light;
    logic               r_flashing;

    logic [1:0]         w_n_state;
    logic [DW-1:0]      w_n_dir;
    logic [DW-1:0]      w_dir_inc;
    logic               w_n_off;
    logic [N_DIR-1:0]   w_n_pend;
    logic [N_DIR-1:0]   w_n_walk;
    logic               w_load;
    logic [CNT_W-1:0]   w_load_val;
    logic               w_zero;

    function automatic logic [2*N_DIR-1:0] f_lamps(input logic [1:0] st,
                                                   input logic [DW-1:0] dir,
                                                   input logic off);
        logic [2*N_DIR-1:0] l;
        l = '0;
        for (int d = 0; d < N_DIR; d++) begin
            l[2*d +: 2] = LAMP_RED;
            if (DW'(d) == dir) begin
                if (st == ST_GREEN)
                    l[2*d +: 2] = LAMP_GREEN;
                else if (st == ST_YELLOW)
                    l[2*d +: 2] = LAMP_YELLOW;
            end
            if (st == ST_FLASH)
                l[2*d +: 2] = off ? LAMP_OFF : LAMP_RED;
        end
        return l;
    endfunction

    assign w_dir_inc = (r_dir == DW'(N_DIR - 1)) ? '0 : r_dir + 1'b1;

    // Transitions happen only on the last tick of a phase; everything else holds.
    always_comb begin
        w_n_state  = r_state;
        w_n_dir    = r_dir;
        w_n_off    = r_off;
        w_n_walk   = r_walk;
        w_n_pend   = r_pend | bus.ped_req;
        w_load     = 1'b0;
        w_load_val = CNT_W'(ALLRED_CYC - 1);
        if (bus.en && w_zero) begin
            w_load = 1'b1;
            case (r_state)
                ST_GREEN: begin
                    w_n_state  = ST_YELLOW;
                    w_n_walk   = '0;
                    w_load_val = CNT_W'(YELLOW_CYC - 1);
                end
                ST_YELLOW: begin
                    w_n_state  = ST_ALLRED;
                    w_load_val = CNT_W'(ALLRED_CYC - 1);
                end
                ST_ALLRED: begin
                    if (bus.flash_mode) begin
                        w_n_state  = ST_FLASH;
                        w_n_off    = 1'b0;
                        w_load_val = CNT_W'(FLASH_CYC - 1);
                    end else begin
                        w_n_state           = ST_GREEN;
                        w_n_dir             = w_dir_inc;
                        w_n_walk            = '0;
                        w_n_walk[w_dir_inc] = r_pend[w_dir_inc];
                        // A request on the entry edge itself is kept for the next green.
                        w_n_pend[w_dir_inc] = bus.ped_req[w_dir_inc];
                        w_load_val          = CNT_W'(GREEN_CYC - 1);
                    end
                end
                default: begin
                    if (bus.flash_mode) begin
                        w_n_off    = ~r_off;
                        w_load_val = CNT_W'(FLASH_CYC - 1);
                    end else begin
                        w_n_state  = ST_ALLRED;
                        w_load_val = CNT_W'(ALLRED_CYC - 1);
                    end
                end
            endcase
        end
    end

    tl_phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk        (clk),
        .i_load     (reset | w_load),
        .i_load_val (reset ? CNT_W'(ALLRED_CYC - 1) : w_load_val),
        .i_en       (bus.en),
        .o_zero     (w_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_ALLRED;
            r_dir      <= DW'(N_DIR - 1);
            r_off      <= 1'b0;
            r_pend     <= '0;
            r_walk     <= '0;
            r_light    <= {N_DIR{LAMP_RED}};
            r_flashing <= 1'b0;
        end else begin
            r_state    <= w_n_state;
            r_dir      <= w_n_dir;
            r_off      <= w_n_off;
            r_pend     <= w_n_pend;
            r_walk     <= w_n_walk;
            r_light    <= f_lamps(w_n_state, w_n_dir, w_n_off);
            r_flashing <= (w_n_state == ST_FLASH);
        end
    end

    assign bus.light      = r_light;
    assign bus.walk       = r_walk;
    assign bus.active_dir = r_dir;
    assign bus.flashing   = r_flashing;

endmodule
